// File: rtl/knn_mem_pkg.sv
// Shared definitions for the SDRAM port arbiter: FSM encoding, default widths
// and the bit positions of the two clients in request/grant vectors.
package knn_mem_pkg;

    localparam int DEF_ADDR_W = 25;
    localparam int DEF_W      = 16;

    // Bit positions of each client inside two-bit request/grant vectors
    localparam int CLIENT_RD = 0;
    localparam int CLIENT_WR = 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_CMD = 2'd1,
        WR_CMD = 2'd2
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin arbiter. 'last' is set when the previous winner was
// the write client (index 1), so a tie goes to whichever client did not win
// last time. The grant is one-hot or zero when nothing is requested.
module rr_arbiter2
    import knn_mem_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] gnt
);

    // Pick a single winner; on a tie prefer the client that lost last time
    always_comb begin
        gnt = 2'b00;
        if (req[CLIENT_RD] && req[CLIENT_WR]) begin
            if (last) begin
                gnt[CLIENT_RD] = 1'b1;
            end else begin
                gnt[CLIENT_WR] = 1'b1;
            end
        end else if (req[CLIENT_RD]) begin
            gnt[CLIENT_RD] = 1'b1;
        end else if (req[CLIENT_WR]) begin
            gnt[CLIENT_WR] = 1'b1;
        end
    end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Shares one Avalon-style SDRAM port between a read client and a write client.
// One command is presented at a time and held until the controller drops
// mem_waitrequest. Outstanding reads are counted so that writes never
// overtake pending reads, and read data is handed back in order.
module sdram_port_arbiter
    import knn_mem_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int W        = DEF_W,
    parameter int MAX_PEND = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_gnt,
    output logic [W-1:0]      rd_data,
    output logic              rd_valid,

    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W-1:0]      wr_data,
    output logic              wr_gnt,

    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [W-1:0]      mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [W-1:0]      mem_readdata,
    input  logic              mem_readdatavalid,

    output logic              busy,
    output logic              err
);

    localparam int PEND_W = $clog2(MAX_PEND + 1);

    arb_state_t        state;
    arb_state_t        state_next;
    logic [PEND_W-1:0] pending;
    logic              last_wr;
    logic [1:0]        eligible;
    logic [1:0]        pick;
    logic              return_ok;
    logic              return_spurious;

    // A read may go out while there is room for another outstanding read;
    // a write only once every earlier read has come back, so it cannot
    // overtake data still in flight.
    always_comb begin
        eligible            = 2'b00;
        eligible[CLIENT_RD] = rd_req && (pending < PEND_W'(MAX_PEND));
        eligible[CLIENT_WR] = wr_req && (pending == '0);
    end

    rr_arbiter2 u_rr (
        .req  (eligible),
        .last (last_wr),
        .gnt  (pick)
    );

    assign return_ok       = mem_readdatavalid && (pending != '0);
    assign return_spurious = mem_readdatavalid && (pending == '0);

    // Next-state and command/grant outputs; the arbiter result matters only in IDLE
    always_comb begin
        state_next = state;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        rd_gnt     = 1'b0;
        wr_gnt     = 1'b0;
        case (state)
            IDLE: begin
                if (pick[CLIENT_RD]) begin
                    state_next = RD_CMD;
                end else if (pick[CLIENT_WR]) begin
                    state_next = WR_CMD;
                end
            end
            RD_CMD: begin
                mem_read = 1'b1;
                if (!mem_waitrequest) begin
                    rd_gnt     = 1'b1;
                    state_next = IDLE;
                end
            end
            WR_CMD: begin
                mem_write = 1'b1;
                if (!mem_waitrequest) begin
                    wr_gnt     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Remember which client was granted last for the round-robin tie break
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_wr <= 1'b0;
        end else if (rd_gnt) begin
            last_wr <= 1'b0;
        end else if (wr_gnt) begin
            last_wr <= 1'b1;
        end
    end

    // Outstanding-read counter; a return with nothing pending is flagged and sticks
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending <= '0;
            err     <= 1'b0;
        end else begin
            if (return_spurious) begin
                err <= 1'b1;
            end
            case ({rd_gnt, return_ok})
                2'b10:   pending <= pending + PEND_W'(1);
                2'b01:   pending <= pending - PEND_W'(1);
                default: pending <= pending;
            endcase
        end
    end

    // Capture the winner's address (and write data) when leaving IDLE; held until accept
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_address   <= '0;
            mem_writedata <= '0;
        end else if (state == IDLE) begin
            if (pick[CLIENT_RD]) begin
                mem_address <= rd_addr;
            end else if (pick[CLIENT_WR]) begin
                mem_address   <= wr_addr;
                mem_writedata <= wr_data;
            end
        end
    end

    // Register returning read data for the read client
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= mem_readdatavalid;
            if (mem_readdatavalid) begin
                rd_data <= mem_readdata;
            end
        end
    end

    assign busy = (state != IDLE) || (pending != '0);

endmodule
